// File: rtl/frame_capture_controller.sv
// Frame capture controller: arms on start_i and waits for the end of vertical
// blanking. It then writes each valid camera pixel to consecutive frame-RAM
// addresses, and closes the frame on a full pixel count or on the next vsync.
// Optional build macro: FRAME_CAPTURE_COUNT_EN adds the 16-bit frame_count_o.
module frame_capture_controller #(
    parameter int unsigned FRAME_WIDTH  = 320,
    parameter int unsigned FRAME_HEIGHT = 240,
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned ADDR_WIDTH   = 17
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  vsync_i,
    input  logic                  pixel_valid_i,
    input  logic [DATA_WIDTH-1:0] pixel_data_i,
    output logic                  write_en_o,
    output logic [ADDR_WIDTH-1:0] write_address_o,
    output logic [DATA_WIDTH-1:0] write_data_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  frame_short_o
`ifdef FRAME_CAPTURE_COUNT_EN
    ,
    output logic [15:0]           frame_count_o
`endif
);

    localparam int unsigned FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_vsync;
    logic [ADDR_WIDTH-1:0]   r_count;

    logic                    w_vsync_fall;
    logic                    w_vsync_rise;
    logic                    w_accept;
    logic                    w_last_pixel;
    logic                    w_frame_end;

    // vsync edges against the previous-cycle copy; a pixel is taken only while capturing
    assign w_vsync_fall = r_vsync & ~vsync_i;
    assign w_vsync_rise = ~r_vsync & vsync_i;
    assign w_accept     = (r_state == ST_CAPTURE) & pixel_valid_i;
    assign w_last_pixel = w_accept & (r_count == LAST_ADDR);
    assign w_frame_end  = (r_state == ST_CAPTURE) & (w_last_pixel | w_vsync_rise);

    // Capture FSM with registered RAM-write and status outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state         <= ST_IDLE;
            r_vsync         <= 1'b0;
            r_count         <= '0;
            write_en_o      <= 1'b0;
            write_address_o <= '0;
            write_data_o    <= '0;
            busy_o          <= 1'b0;
            frame_done_o    <= 1'b0;
            frame_short_o   <= 1'b0;
        end else begin
            r_vsync      <= vsync_i;
            write_en_o   <= 1'b0;
            frame_done_o <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // a vsync edge here is deliberately ignored; only start_i arms
                    if (start_i) begin
                        r_state <= ST_ARMED;
                        busy_o  <= 1'b1;
                    end else begin
                        busy_o  <= 1'b0;
                    end
                end

                ST_ARMED: begin
                    busy_o <= 1'b1;
                    if (w_vsync_fall) begin
                        r_state <= ST_CAPTURE;
                        r_count <= '0;
                    end
                end

                ST_CAPTURE: begin
                    busy_o <= 1'b1;
                    // a pixel coincident with the closing vsync edge is still written
                    if (w_accept) begin
                        write_en_o      <= 1'b1;
                        write_address_o <= r_count;
                        write_data_o    <= pixel_data_i;
                        // hold at the last address so it can never wrap
                        if (!w_last_pixel) begin
                            r_count <= r_count + ADDR_WIDTH'(1);
                        end
                    end
                    if (w_frame_end) begin
                        r_state       <= ST_DONE;
                        frame_done_o  <= 1'b1;
                        frame_short_o <= ~w_last_pixel;
                    end
                end

                ST_DONE: begin
                    if (continuous_i) begin
                        r_state <= ST_ARMED;
                        busy_o  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_CAPTURE_COUNT_EN
    // Completed-frame counter, stepping with each frame_done_o pulse and wrapping at 16 bits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            frame_count_o <= '0;
        end else if (w_frame_end) begin
            frame_count_o <= frame_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_capture_controller.sv
// Directed bench for frame_capture_controller on a reduced 16x8 frame.
// Pixel writes are scored through an expected-write queue; frame-end pulses are logged.
module tb_frame_capture_controller;

    localparam int unsigned FW   = 16;
    localparam int unsigned FH   = 8;
    localparam int unsigned DW   = 12;
    localparam int unsigned AW   = 7;
    localparam int unsigned NPIX = FW * FH;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic          continuous_i;
    logic          vsync_i;
    logic          pixel_valid_i;
    logic [DW-1:0] pixel_data_i;
    logic          write_en_o;
    logic [AW-1:0] write_address_o;
    logic [DW-1:0] write_data_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          frame_short_o;
`ifdef FRAME_CAPTURE_COUNT_EN
    logic [15:0]   frame_count_o;
`endif

    frame_capture_controller #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .continuous_i   (continuous_i),
        .vsync_i        (vsync_i),
        .pixel_valid_i  (pixel_valid_i),
        .pixel_data_i   (pixel_data_i),
        .write_en_o     (write_en_o),
        .write_address_o(write_address_o),
        .write_data_o   (write_data_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .frame_short_o  (frame_short_o)
`ifdef FRAME_CAPTURE_COUNT_EN
        ,
        .frame_count_o  (frame_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_wr = 0;
    int            n_done = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] done_addr = '0;
    logic          done_short = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest outstanding pixel
    always @(negedge clk_i) begin
        if (write_en_o) begin
            if (exp_q.size() == 0) begin
                check("write_without_pixel", 32'(exp_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(write_address_o), 32'(e.addr));
                check("write_data", 32'(write_data_o), 32'(e.data));
            end
            n_wr++;
            last_addr = write_address_o;
        end
        if (frame_done_o) begin
            n_done++;
            done_addr  = last_addr;
            done_short = frame_short_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One pixel cycle; when acc is set the DUT is expected to write it
    task automatic pix(input logic [DW-1:0] d, input bit acc);
        pixel_valid_i = 1'b1;
        pixel_data_i  = d;
        if (acc) begin
            exp_q.push_back({exp_addr, d});
            exp_addr = exp_addr + AW'(1);
        end
        tick();
        pixel_valid_i = 1'b0;
    endtask

    // start_i in IDLE, then a vsync falling edge while ARMED
    task automatic arm();
        vsync_i = 1'b1;
        idle(2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("armed_busy", 32'(busy_o), 32'd1);
        vsync_i = 1'b0;
        tick();
        exp_addr = '0;
    endtask

    initial begin
        int w0;
        int d0;
        reset_i       = 1'b1;
        start_i       = 1'b0;
        continuous_i  = 1'b0;
        vsync_i       = 1'b1;
        pixel_valid_i = 1'b0;
        pixel_data_i  = '0;

        // reset state
        idle(2);
        check("rst_write_en", 32'(write_en_o), 32'd0);
        check("rst_addr", 32'(write_address_o), 32'd0);
        check("rst_data", 32'(write_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(frame_done_o), 32'd0);
        check("rst_short", 32'(frame_short_o), 32'd0);
`ifdef FRAME_CAPTURE_COUNT_EN
        check("rst_count", 32'(frame_count_o), 32'd0);
`endif
        reset_i = 1'b0;
        tick();

        // full frame; a stray start_i mid-frame must be ignored
        w0 = n_wr; d0 = n_done;
        arm();
        for (int i = 0; i < int'(NPIX); i++) begin
            start_i = (i == 3);
            pix(DW'(i % 4096), 1'b1);
        end
        start_i = 1'b0;
        idle(3);
        check("full_writes", 32'(n_wr - w0), 32'(NPIX));
        check("full_done_pulses", 32'(n_done - d0), 32'd1);
        check("full_done_addr", 32'(done_addr), 32'(NPIX - 1));
        check("full_short", 32'(done_short), 32'd0);
        check("full_idle", 32'(busy_o), 32'd0);
        check("full_addr_hold", 32'(write_address_o), 32'(NPIX - 1));
        check("full_q_empty", 32'(exp_q.size()), 32'd0);

        // short frame closed by vsync after 50 pixels
        w0 = n_wr; d0 = n_done;
        arm();
        for (int i = 0; i < 50; i++) pix(DW'($urandom), 1'b1);
        vsync_i = 1'b1;
        tick();
        idle(3);
        check("short_writes", 32'(n_wr - w0), 32'd50);
        check("short_done_pulses", 32'(n_done - d0), 32'd1);
        check("short_done_addr", 32'(done_addr), 32'd49);
        check("short_flag", 32'(done_short), 32'd1);
        check("short_flag_held", 32'(frame_short_o), 32'd1);
        check("short_idle", 32'(busy_o), 32'd0);

        // overflow: extra pixels after the full frame are dropped
        w0 = n_wr; d0 = n_done;
        arm();
        for (int i = 0; i < int'(NPIX) + 5; i++) pix(DW'($urandom), i < int'(NPIX));
        idle(3);
        check("ovf_writes", 32'(n_wr - w0), 32'(NPIX));
        check("ovf_done_pulses", 32'(n_done - d0), 32'd1);
        check("ovf_short", 32'(done_short), 32'd0);
        check("ovf_last_addr", 32'(last_addr), 32'(NPIX - 1));

        // pixel coincident with vsync rise at count 9
        w0 = n_wr; d0 = n_done;
        arm();
        for (int i = 0; i < 9; i++) pix(DW'($urandom), 1'b1);
        vsync_i = 1'b1;
        pix(12'hA5C, 1'b1);
        idle(3);
        check("coinc_writes", 32'(n_wr - w0), 32'd10);
        check("coinc_done_addr", 32'(done_addr), 32'd9);
        check("coinc_short", 32'(done_short), 32'd1);
        check("coinc_done_pulses", 32'(n_done - d0), 32'd1);

        // reset mid-capture at pixel 50 aborts the frame
        w0 = n_wr; d0 = n_done;
        arm();
        for (int i = 0; i < 50; i++) pix(DW'($urandom), 1'b1);
        reset_i       = 1'b1;
        pixel_valid_i = 1'b1;
        pixel_data_i  = 12'h123;
        tick();
        check("abort_write_en", 32'(write_en_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(frame_done_o), 32'd0);
        check("abort_short", 32'(frame_short_o), 32'd0);
        reset_i       = 1'b0;
        pixel_valid_i = 1'b0;
        vsync_i       = 1'b1;
        idle(2);
        vsync_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) pix(DW'($urandom), 1'b0);
        idle(3);
        check("abort_writes", 32'(n_wr - w0), 32'd50);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        check("abort_still_idle", 32'(busy_o), 32'd0);

        // continuous mode: two frames, second restarts at address 0
        w0 = n_wr; d0 = n_done;
        continuous_i = 1'b1;
        arm();
        for (int i = 0; i < 20; i++) pix(DW'($urandom), 1'b1);
        vsync_i = 1'b1;
        tick();
        tick();
        check("cont_rearmed_busy", 32'(busy_o), 32'd1);
        check("cont_first_done", 32'(n_done - d0), 32'd1);
        check("cont_first_addr", 32'(done_addr), 32'd19);
        vsync_i = 1'b0;
        tick();
        exp_addr = '0;
        for (int i = 0; i < 10; i++) pix(DW'($urandom), 1'b1);
        continuous_i = 1'b0;
        vsync_i      = 1'b1;
        tick();
        idle(3);
        check("cont_writes", 32'(n_wr - w0), 32'd30);
        check("cont_done_pulses", 32'(n_done - d0), 32'd2);
        check("cont_second_addr", 32'(done_addr), 32'd9);
        check("cont_idle", 32'(busy_o), 32'd0);
        check("cont_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef FRAME_CAPTURE_COUNT_EN
        check("cont_frame_count", 32'(frame_count_o), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
